// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter
//   Two-port round-robin arbiter in front of a single-port data memory with
//   a one-cycle registered read. Each accepted request runs one transaction
//   IDLE -> ISSUE -> (WAIT) -> DONE. Out-of-range addresses skip the memory
//   and complete straight from IDLE with err set.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   req0/req1, we0/we1       per-port request and write-enable
//   addr0/addr1              per-port byte address
//   wdata0/wdata1            per-port write data
//   ack0/ack1                one-cycle completion pulse for the served port
//   rdata                    read result, non-zero only during a read ack
//   err                      out-of-range flag, valid with ack
//   busy                     high whenever the FSM is not in IDLE
//   mem_enable               memory write strobe (1 = write)
//   mem_address              memory address
//   mem_dataInput            memory write data
//   mem_dataOutput           memory read data, one cycle after the address
module data_memory_arbiter #(
    parameter int MEM_DEPTH = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata,
    output logic       err,
    output logic       busy,
    output logic       mem_enable,
    output logic [7:0] mem_address,
    output logic [7:0] mem_dataInput,
    input  logic [7:0] mem_dataOutput
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [8:0] DEPTH_LIM = 9'(MEM_DEPTH);

    state_t     state;
    logic       ptr;        // port that wins a tie
    logic       win;        // port being served
    logic       we_q;       // latched direction of the transaction in flight

    logic       grant;
    logic       sel_we;
    logic [7:0] sel_addr;
    logic [7:0] sel_wdata;
    logic       in_range;

    // A lone requester always wins; on a tie the pointer decides.
    always_comb begin
        grant     = (req0 && req1) ? ptr : req1;
        sel_we    = grant ? we1    : we0;
        sel_addr  = grant ? addr1  : addr0;
        sel_wdata = grant ? wdata1 : wdata0;
        in_range  = ({1'b0, sel_addr} < DEPTH_LIM);
    end

    // Outputs are registered: each branch loads the values belonging to
    // the state being entered, so they line up with the new state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            ptr           <= 1'b0;
            win           <= 1'b0;
            we_q          <= 1'b0;
            ack0          <= 1'b0;
            ack1          <= 1'b0;
            err           <= 1'b0;
            busy          <= 1'b0;
            mem_enable    <= 1'b0;
            rdata         <= '0;
            mem_address   <= '0;
            mem_dataInput <= '0;
        end else begin
            ack0          <= 1'b0;
            ack1          <= 1'b0;
            err           <= 1'b0;
            mem_enable    <= 1'b0;
            rdata         <= '0;
            mem_address   <= '0;
            mem_dataInput <= '0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        win  <= grant;
                        we_q <= sel_we;
                        busy <= 1'b1;
                        if (in_range) begin
                            state         <= ISSUE;
                            mem_enable    <= sel_we;
                            mem_address   <= sel_addr;
                            mem_dataInput <= sel_wdata;
                        end else begin
                            // Out of range: complete next cycle, no memory access.
                            state <= DONE;
                            err   <= 1'b1;
                            ack0  <= ~grant;
                            ack1  <= grant;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ISSUE: begin
                    busy <= 1'b1;
                    if (we_q) begin
                        state <= DONE;
                        ack0  <= ~win;
                        ack1  <= win;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // Memory output now reflects the address issued last cycle.
                    state <= DONE;
                    busy  <= 1'b1;
                    rdata <= mem_dataOutput;
                    ack0  <= ~win;
                    ack1  <= win;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ptr   <= ~win;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
module tb_data_memory_arbiter;

    localparam int MEM_DEPTH = 33;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       ack0, ack1, err, busy, mem_enable;
    logic [7:0] rdata, mem_address, mem_dataInput, mem_dataOutput;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    data_memory_arbiter #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .req0           (req0),
        .req1           (req1),
        .we0            (we0),
        .we1            (we1),
        .addr0          (addr0),
        .addr1          (addr1),
        .wdata0         (wdata0),
        .wdata1         (wdata1),
        .ack0           (ack0),
        .ack1           (ack1),
        .rdata          (rdata),
        .err            (err),
        .busy           (busy),
        .mem_enable     (mem_enable),
        .mem_address    (mem_address),
        .mem_dataInput  (mem_dataInput),
        .mem_dataOutput (mem_dataOutput)
    );

    // Memory: unwritten locations read as addr ^ 0x5A; registered read.
    logic [7:0] mem [256];
    bit   [255:0] wr_flag;
    always @(posedge clk) begin
        if (mem_enable) begin
            mem[mem_address]     <= mem_dataInput;
            wr_flag[mem_address] <= 1'b1;
        end
        mem_dataOutput <= wr_flag[mem_address] ? mem[mem_address] : (mem_address ^ 8'h5A);
    end

    // Reference model state
    logic [7:0] ref_mem [256];
    logic       m_ptr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int lat(input logic w, input logic e);
        return e ? 1 : (w ? 2 : 3);
    endfunction

    // Transaction-level model: serve ports in arbitration order, read then write.
    task automatic model_run(input logic r0, input logic r1, input logic w0, input logic w1,
                             input logic [7:0] a0, input logic [7:0] a1,
                             input logic [7:0] d0, input logic [7:0] d1,
                             output logic first, output logic e0, output logic e1,
                             output logic [7:0] rd0, output logic [7:0] rd1);
        logic p, w, e;
        logic [7:0] a, d, rd;
        if (r0 && r1) first = m_ptr;
        else if (r0)  first = 1'b0;
        else          first = 1'b1;
        e0 = 0; e1 = 0; rd0 = 0; rd1 = 0;
        for (int k = 0; k < ((r0 && r1) ? 2 : 1); k++) begin
            p  = (k == 0) ? first : ~first;
            w  = p ? w1 : w0;
            a  = p ? a1 : a0;
            d  = p ? d1 : d0;
            e  = (int'(a) >= MEM_DEPTH);
            rd = (!w && !e) ? ref_mem[a] : 8'h00;
            if (w && !e) ref_mem[a] = d;
            if (p) begin e1 = e; rd1 = rd; end
            else   begin e0 = e; rd0 = rd; end
            m_ptr = ~p;
        end
    endtask

    // Drives one or two simultaneous requests from an IDLE cycle and checks
    // every cycle until both complete. Entered and left at posedge+1.
    task automatic check_txns(input logic r0, input logic r1, input logic w0, input logic w1,
                              input logic [7:0] a0, input logic [7:0] a1,
                              input logic [7:0] d0, input logic [7:0] d1,
                              input logic first, input logic e0, input logic e1,
                              input logic [7:0] rd0, input logic [7:0] rd1);
        int lf, ls, c0, c1, idle2;
        logic both, wf, ef, ws, es, me, s0, s1, done0, done1;
        logic [7:0] af, df, as_, ds;
        both  = r0 && r1;
        wf = first ? w1 : w0;  ef = first ? e1 : e0;  af = first ? a1 : a0;  df = first ? d1 : d0;
        ws = first ? w0 : w1;  es = first ? e0 : e1;  as_ = first ? a0 : a1; ds = first ? d0 : d1;
        lf = lat(wf, ef);
        ls = lat(ws, es);
        c0 = -1; c1 = -1;
        if (first) begin c1 = lf; if (both) c0 = lf + 1 + ls; end
        else       begin c0 = lf; if (both) c1 = lf + 1 + ls; end
        idle2 = both ? lf + 1 : -1;
        done0 = !r0; done1 = !r1;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        for (int c = 0; c < 16 && !(done0 && done1); c++) begin
            @(negedge clk);
            chk("ack", {30'd0, ack1, ack0}, {30'd0, c == c1, c == c0});
            chk("busy", busy, !(c == 0 || c == idle2));
            s0 = ack0; s1 = ack1;
            if (ack0 && c == c0) begin
                chk("err0", err, e0);
                chk("rdata0", rdata, rd0);
            end
            if (ack1 && c == c1) begin
                chk("err1", err, e1);
                chk("rdata1", rdata, rd1);
            end
            me = (c == 1 && wf && !ef) || (both && c == lf + 2 && ws && !es);
            chk("mem_enable", mem_enable, me);
            if (me && mem_enable) begin
                chk("mem_address", mem_address, (c == 1) ? af : as_);
                chk("mem_dataInput", mem_dataInput, (c == 1) ? df : ds);
            end
            @(posedge clk); #1;
            if (s0) begin req0 = 0; done0 = 1; end
            if (s1) begin req1 = 0; done1 = 1; end
        end
        if (!(done0 && done1)) begin
            chk("ack_timeout", 0, 1);
            req0 = 0; req1 = 0;
            repeat (4) @(posedge clk);
            #1;
        end
    endtask

    task automatic model_txn(input logic r0, input logic r1, input logic w0, input logic w1,
                             input logic [7:0] a0, input logic [7:0] a1,
                             input logic [7:0] d0, input logic [7:0] d1);
        logic f, e0, e1;
        logic [7:0] rd0, rd1;
        model_run(r0, r1, w0, w1, a0, a1, d0, d1, f, e0, e1, rd0, rd1);
        check_txns(r0, r1, w0, w1, a0, a1, d0, d1, f, e0, e1, rd0, rd1);
    endtask

    typedef struct {
        logic       r0, r1, w0, w1;
        logic [7:0] a0, a1, d0, d1;
        logic       first, e0, e1;
        logic [7:0] rd0, rd1;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [11];
        logic f_d, e0_d, e1_d;
        logic [7:0] r0_d, r1_d;
        int   got;

        //            r0 r1 w0 w1  a0     a1     d0     d1     first e0 e1 rd0    rd1
        tbl[0]  = '{1, 1, 1, 1, 8'd10, 8'd11, 8'h11, 8'h22, 0, 0, 0, 8'h00, 8'h00};
        tbl[1]  = '{1, 0, 1, 0, 8'd5,  8'd0,  8'hA5, 8'h00, 0, 0, 0, 8'h00, 8'h00};
        tbl[2]  = '{1, 1, 1, 1, 8'd14, 8'd15, 8'h66, 8'h77, 1, 0, 0, 8'h00, 8'h00};
        tbl[3]  = '{0, 1, 0, 0, 8'd0,  8'd5,  8'h00, 8'h00, 1, 0, 0, 8'h00, 8'hA5};
        tbl[4]  = '{1, 0, 0, 0, 8'd40, 8'd0,  8'h00, 8'h00, 0, 1, 0, 8'h00, 8'h00};
        tbl[5]  = '{1, 1, 0, 0, 8'd10, 8'd11, 8'h00, 8'h00, 1, 0, 0, 8'h11, 8'h22};
        tbl[6]  = '{1, 1, 0, 1, 8'd32, 8'd33, 8'h00, 8'h99, 1, 0, 1, 8'h7A, 8'h00};
        tbl[7]  = '{0, 1, 0, 0, 8'd0,  8'd0,  8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h5A};
        tbl[8]  = '{1, 1, 0, 0, 8'd15, 8'd14, 8'h00, 8'h00, 0, 0, 0, 8'h77, 8'h66};
        tbl[9]  = '{1, 0, 0, 0, 8'd255, 8'd0, 8'h00, 8'h00, 0, 1, 0, 8'h00, 8'h00};
        tbl[10] = '{1, 1, 0, 1, 8'd14, 8'd14, 8'h00, 8'h01, 1, 0, 0, 8'h01, 8'h00};

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
        m_ptr = 0;
        rst = 0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;

        #2;
        chk("reset_outputs", {ack0, ack1, err, busy, mem_enable, rdata, mem_address, mem_dataInput}, 0);
        @(posedge clk); #1;
        rst = 1;

        // Directed table, checked against hand-derived expectations; the
        // model is run alongside so its state tracks the DUT.
        for (int i = 0; i < 11; i++) begin
            model_run(tbl[i].r0, tbl[i].r1, tbl[i].w0, tbl[i].w1, tbl[i].a0, tbl[i].a1,
                      tbl[i].d0, tbl[i].d1, f_d, e0_d, e1_d, r0_d, r1_d);
            check_txns(tbl[i].r0, tbl[i].r1, tbl[i].w0, tbl[i].w1, tbl[i].a0, tbl[i].a1,
                       tbl[i].d0, tbl[i].d1, tbl[i].first, tbl[i].e0, tbl[i].e1,
                       tbl[i].rd0, tbl[i].rd1);
        end

        // Inputs changed during ISSUE must not leak into the access.
        req1 = 1; we1 = 1; addr1 = 8'd20; wdata1 = 8'h3C;
        @(posedge clk); #1;
        addr1 = 8'd21; wdata1 = 8'hFF;
        @(negedge clk);
        chk("issue_mem_enable", mem_enable, 1);
        chk("issue_address", mem_address, 8'd20);
        chk("issue_data", mem_dataInput, 8'h3C);
        got = -1;
        for (int c = 2; c < 10 && got < 0; c++) begin
            @(negedge clk);
            if (ack1) got = c;
            @(posedge clk); #1;
        end
        chk("issue_ack_cycle", got, 2);
        req1 = 0;
        ref_mem[20] = 8'h3C;
        m_ptr = 0;
        model_txn(1, 1, 0, 0, 8'd20, 8'd21, 8'h00, 8'h00);

        // Reset during WAIT aborts the read and clears the pointer.
        model_txn(1, 0, 1, 0, 8'd3, 8'd0, 8'hC3, 8'h00);
        req0 = 1; we0 = 0; addr0 = 8'd7;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 0;
        #1;
        chk("abort_outputs", {ack0, ack1, err, busy, mem_enable, rdata, mem_address, mem_dataInput}, 0);
        req0 = 0;
        @(posedge clk); #1;
        rst = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("abort_quiet", {ack0, ack1, mem_enable, busy}, 0);
            @(posedge clk); #1;
        end
        m_ptr = 0;
        model_txn(1, 1, 0, 0, 8'd7, 8'd3, 8'h00, 8'h00);

        // Randomized traffic against the model.
        for (int n = 0; n < 200; n++) begin
            int unsigned r;
            logic [7:0] ra0, ra1;
            r   = $urandom_range(1, 3);
            ra0 = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(33, 255)) : 8'($urandom_range(0, 32));
            ra1 = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(33, 255)) : 8'($urandom_range(0, 32));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            model_txn(r[0], r[1], 1'($urandom), 1'($urandom), ra0, ra1,
                      8'($urandom), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_arbiter.md
DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 Parameter: MEM_DEPTH, default 33, number of valid data-memory locations; legal addresses are 0..MEM_DEPTH-1.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 req0 / req1  in  1  request from port 0 (CPU) / port 1 (DMA/debug).
REQ-005 we0 / we1  in  1  1 = write, 0 = read, per port.
REQ-006 addr0 / addr1  in  8  byte address, per port.
REQ-007 wdata0 / wdata1  in  8  write data, per port.
REQ-008 ack0 / ack1  out  1  one-cycle completion pulse, per port.
REQ-009 rdata  out  8  read result, shared; valid only while ack0 or ack1 is high for a read.
REQ-010 err  out  1  out-of-range flag; valid only while ack0 or ack1 is high.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 mem_enable  out  1  memory write strobe: 1 = write, 0 = read.
REQ-013 mem_address / mem_dataInput  out  8  memory address and write data.
REQ-014 mem_dataOutput  in  8  memory read data, registered one cycle after the address is presented.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT, DONE; all outputs SHALL be decoded from registered state and latched fields, with no combinational input-to-output paths.
REQ-016 IDLE: no req -> stay; any req -> latch the winner's we/addr/wdata and the winner id; go ISSUE if addr < MEM_DEPTH, else go DONE with err latched high.
REQ-017 Arbitration SHALL be round-robin: a single requester always wins; on simultaneous requests the port named by priority pointer ptr wins; ptr resets to 0.
REQ-018 On exit from DONE, ptr SHALL become the port not just served, including for err transactions.
REQ-019 ISSUE: drive mem_address/mem_dataInput from the latched fields and mem_enable = latched we; then go DONE for a write or WAIT for a read.
REQ-020 mem_enable SHALL be 1 only in ISSUE for a write; in every other state and cycle it SHALL be 0.
REQ-021 WAIT: capture mem_dataOutput into the rdata register; go DONE.
REQ-022 DONE: assert ack of the latched winner for exactly one cycle; rdata = captured value for a read, 0 for a write or err; go IDLE.
REQ-023 Latency, counted from the IDLE cycle sampling req (cycle 0): write ack in cycle 2; read ack in cycle 3; out-of-range ack in cycle 1.
REQ-024 Requesters SHALL hold req/we/addr/wdata stable until ack and drop or change them at the edge ending the ack cycle; any req seen high in IDLE is a new request.
REQ-025 Changes to inputs after the IDLE latch SHALL NOT affect the transaction in flight.
REQ-026 The losing requester SHALL remain pending and be served in the next IDLE cycle; worst-case wait is one transaction.
REQ-027 ack0 and ack1 SHALL never be high together; at most one memory write occurs per transaction.

Reset
REQ-028 rst low SHALL immediately force: state IDLE, ptr = 0, ack0/ack1/err/busy/mem_enable = 0, rdata/mem_address/mem_dataInput = 0.
REQ-029 rst asserted mid-transaction SHALL abort it: no ack and no write after release; the first posedge with rst high evaluates IDLE normally.

Verification
REQ-030 Port 0 write addr 5, data 0xA5, single requester -> mem_enable = 1 with mem_address = 5 / mem_dataInput = 0xA5 in cycle 1; ack0 in cycle 2; err = 0.
REQ-031 Port 1 read addr 5 after REQ-030 -> ack1 in cycle 3 with rdata = 0xA5; mem_enable stays 0 throughout.
REQ-032 req0 and req1 both high from reset, both writes -> port 0 served first, port 1 ack exactly 3 cycles after ack0; repeated contention alternates winners.
REQ-033 Port 0 read addr 40 (MEM_DEPTH = 33) -> ack0 in cycle 1, err = 1, rdata = 0, no ISSUE and no memory access.
REQ-034 Read in flight with rst pulsed low during WAIT -> outputs zero immediately, no ack; a later request completes normally with ptr = 0.
REQ-035 Port 1 changes addr/wdata during ISSUE -> the memory access uses the values latched in IDLE.
